// File: rtl/pwm_multi_controller.sv
// Multi-channel PWM controller.
// All channels share one period counter advanced by a programmable prescaler.
// Duty, period and prescale values are written into pending registers and
// copied into the active set only on the wrap cycle, so every period runs
// with a single consistent set of values.
module pwm_multi_controller #(
    parameter int NUM_CH         = 3,
    parameter int CNT_W          = 20,
    parameter int PRESCALE_W     = 8,
    parameter int DEFAULT_PERIOD = 100000,
    parameter int DEFAULT_DUTY   = 5000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  cfg_wr,
    input  logic [7:0]            cfg_addr,
    input  logic [CNT_W-1:0]      cfg_data,
    input  logic [NUM_CH-1:0]     ch_en,
    input  logic [NUM_CH-1:0]     ch_inv,
    output logic [NUM_CH-1:0]     pwm_out,
    output logic                  period_tick,
    output logic                  cfg_err
);

    localparam logic [7:0]       ADDR_PER   = 8'hFE;
    localparam logic [7:0]       ADDR_PRESC = 8'hFF;
    localparam logic [7:0]       ADDR_LIM   = 8'(NUM_CH);
    localparam logic [CNT_W-1:0] RST_PER    = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] RST_DUTY   = CNT_W'(DEFAULT_DUTY);

    logic [PRESCALE_W-1:0] presc_cnt;
    logic [PRESCALE_W-1:0] presc_act;
    logic [PRESCALE_W-1:0] presc_pend;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      per_act;
    logic [CNT_W-1:0]      per_pend;
    logic [CNT_W-1:0]      duty_act  [NUM_CH];
    logic [CNT_W-1:0]      duty_pend [NUM_CH];
    logic [NUM_CH-1:0]     en_act;
    logic [NUM_CH-1:0]     inv_act;
    logic [NUM_CH-1:0]     raw;
    logic                  tick;
    logic                  wrap;
    logic                  wrap_p1;
    logic                  wr_per;
    logic                  wr_presc;
    logic                  wr_bad;

    // Prescaler tick, wrap detection and write decode.
    always_comb begin
        tick     = (presc_cnt == presc_act);
        wrap     = tick && (cnt == per_act);
        wr_per   = cfg_wr && (cfg_addr == ADDR_PER) && (cfg_data != '0);
        wr_presc = cfg_wr && (cfg_addr == ADDR_PRESC);
        // A zero period would stall the counter, so it is refused like an unmapped address.
        wr_bad   = cfg_wr && (((cfg_addr == ADDR_PER) && (cfg_data == '0)) ||
                              ((cfg_addr >= ADDR_LIM) && (cfg_addr < ADDR_PER)));
    end

    // Per-channel compare against the active duty; duty above the period stays high.
    always_comb begin
        raw = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            raw[i] = en_act[i] & (cnt < duty_act[i]);
        end
    end

    // Prescaler and shared period counter.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            presc_cnt <= '0;
            cnt       <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
            cnt       <= wrap ? '0 : cnt + CNT_W'(1);
        end else begin
            presc_cnt <= presc_cnt + PRESCALE_W'(1);
        end
    end

    // Active set loads from pending (pre-write values) only on the wrap cycle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            per_act   <= RST_PER;
            presc_act <= '0;
            en_act    <= '0;
            inv_act   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_act[i] <= RST_DUTY;
            end
        end else if (wrap) begin
            per_act   <= per_pend;
            presc_act <= presc_pend;
            en_act    <= ch_en;
            inv_act   <= ch_inv;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_act[i] <= duty_pend[i];
            end
        end
    end

    // Pending registers written from the configuration port.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            per_pend   <= RST_PER;
            presc_pend <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_pend[i] <= RST_DUTY;
            end
        end else begin
            if (wr_per) begin
                per_pend <= cfg_data;
            end
            if (wr_presc) begin
                presc_pend <= cfg_data[PRESCALE_W-1:0];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_wr && (cfg_addr == 8'(i))) begin
                    duty_pend[i] <= cfg_data;
                end
            end
        end
    end

    // Registered outputs; period_tick lags the wrap by two edges so it lines up
    // with the first pwm_out sample taken from cnt == 0.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pwm_out     <= '0;
            wrap_p1     <= 1'b0;
            period_tick <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            pwm_out     <= raw ^ inv_act;
            wrap_p1     <= wrap;
            period_tick <= wrap_p1;
            cfg_err     <= wr_bad;
        end
    end

endmodule

// File: tb/tb_pwm_multi_controller.sv
// Bench for pwm_multi_controller: directed scenarios plus random traffic,
// each cycle compared against a period-level reference model.
module tb_pwm_multi_controller;

    localparam int NUM_CH     = 3;
    localparam int CNT_W      = 20;
    localparam int PRESCALE_W = 8;
    localparam int DEF_PER    = 199;
    localparam int DEF_DUTY   = 50;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              cfg_wr;
    logic [7:0]        cfg_addr;
    logic [CNT_W-1:0]  cfg_data;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] ch_inv;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_tick;
    logic              cfg_err;

    int checks   = 0;
    int failures = 0;

    pwm_multi_controller #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE_W(PRESCALE_W),
        .DEFAULT_PERIOD(DEF_PER), .DEFAULT_DUTY(DEF_DUTY)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .ch_en(ch_en), .ch_inv(ch_inv), .pwm_out(pwm_out),
        .period_tick(period_tick), .cfg_err(cfg_err)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: position m_k in clocks since the period began; the counter
    // value is m_k / (prescale+1) and the period lasts (per+1)*(prescale+1) clocks.
    int                m_per_act, m_per_pend, m_presc_act, m_presc_pend, m_k;
    int                m_duty_act [NUM_CH];
    int                m_duty_pend[NUM_CH];
    logic [NUM_CH-1:0] m_en, m_inv, m_pwm;
    logic              m_tick, m_err, m_first;

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            m_per_act = DEF_PER;  m_per_pend = DEF_PER;
            m_presc_act = 0;      m_presc_pend = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_duty_act[i] = DEF_DUTY; m_duty_pend[i] = DEF_DUTY;
            end
            m_en = '0; m_inv = '0; m_pwm = '0;
            m_tick = 1'b0; m_err = 1'b0; m_first = 1'b0; m_k = 0;
        end else begin : model_step
            int div, len, slot;
            div  = m_presc_act + 1;
            len  = (m_per_act + 1) * div;
            slot = m_k / div;
            for (int i = 0; i < NUM_CH; i++)
                m_pwm[i] = (m_en[i] && (slot < m_duty_act[i])) ^ m_inv[i];
            m_tick  = m_first;
            m_first = 1'b0;
            m_err   = cfg_wr && ((cfg_addr == 8'hFE && cfg_data == '0) ||
                                 (int'(cfg_addr) >= NUM_CH && int'(cfg_addr) < 254));
            if (m_k == len - 1) begin
                m_per_act = m_per_pend; m_presc_act = m_presc_pend;
                for (int i = 0; i < NUM_CH; i++) m_duty_act[i] = m_duty_pend[i];
                m_en = ch_en; m_inv = ch_inv;
                m_k = 0; m_first = 1'b1;
            end else begin
                m_k = m_k + 1;
            end
            if (cfg_wr) begin
                if (int'(cfg_addr) < NUM_CH) m_duty_pend[int'(cfg_addr)] = int'(cfg_data);
                else if (cfg_addr == 8'hFE && cfg_data != '0) m_per_pend = int'(cfg_data);
                else if (cfg_addr == 8'hFF) m_presc_pend = int'(cfg_data[7:0]);
            end
        end
    end

    task automatic cfg_write(input logic [7:0] a, input logic [CNT_W-1:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk_in);
        cfg_wr = 1'b0;
    endtask

    task automatic wait_tick(input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (period_tick !== 1'b1 && n < budget);
        checks++;
        if (period_tick !== 1'b1) begin
            failures++;
            $display("FAIL %s: period_tick not seen within %0d clk", name, budget);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0; ch_en = '0; ch_inv = '0;
        repeat (3) @(negedge clk_in);
        checks++;
        if ({pwm_out, period_tick, cfg_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 00000", {pwm_out, period_tick, cfg_err});
        end
        rst_in = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_in);
            checks++;
            if ({pwm_out, period_tick, cfg_err} !== {m_pwm, m_tick, m_err} || pwm_out !== '0) begin
                failures++;
                $display("FAIL reset_idle c=%0d: got %b/%b/%b want %b/%b/%b", c,
                         pwm_out, period_tick, cfg_err, m_pwm, m_tick, m_err);
            end
        end
    endtask

    task automatic test_basic();
        int highs, tick_at;
        cfg_write(8'hFE, 9); cfg_write(8'hFF, 0); cfg_write(8'h00, 3);
        ch_en = 3'b001; ch_inv = 3'b000;
        wait_tick(260, "basic_first_wrap");
        highs = 0; tick_at = -1;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) @(negedge clk_in);
            checks++;
            if ({pwm_out, period_tick, cfg_err} !== {m_pwm, m_tick, m_err}) begin
                failures++;
                $display("FAIL basic_model c=%0d: got %b/%b/%b want %b/%b/%b", c,
                         pwm_out, period_tick, cfg_err, m_pwm, m_tick, m_err);
            end
            if (c < 10 && pwm_out[0]) highs++;
            if (c > 0 && period_tick && tick_at < 0) tick_at = c;
            if (c == 0) begin
                checks++;
                if (pwm_out[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_rise_at_tick: got %b want 1", pwm_out[0]);
                end
            end
        end
        checks++;
        if (highs != 3) begin failures++; $display("FAIL basic_high_len: got %0d want 3", highs); end
        checks++;
        if (tick_at != 10) begin failures++; $display("FAIL basic_tick_spacing: got %0d want 10", tick_at); end
    endtask

    task automatic test_duty_extremes();
        int bad;
        cfg_write(8'h01, 0); cfg_write(8'h02, 10);
        ch_en = 3'b111;
        wait_tick(25, "extremes_wrap");
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk_in);
            checks++;
            if ({pwm_out, period_tick, cfg_err} !== {m_pwm, m_tick, m_err}) begin
                failures++;
                $display("FAIL extremes_model c=%0d: got %b/%b/%b want %b/%b/%b", c,
                         pwm_out, period_tick, cfg_err, m_pwm, m_tick, m_err);
            end
            if (pwm_out[2:1] !== 2'b10) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL extremes_const: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_mid_period();
        int highs_a, highs_b;
        wait_tick(15, "mid_sync");
        highs_a = 0; highs_b = 0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk_in);
            checks++;
            if ({pwm_out, period_tick, cfg_err} !== {m_pwm, m_tick, m_err}) begin
                failures++;
                $display("FAIL mid_model c=%0d: got %b/%b/%b want %b/%b/%b", c,
                         pwm_out, period_tick, cfg_err, m_pwm, m_tick, m_err);
            end
            if (c < 10 && pwm_out[0]) highs_a++;
            if (c >= 10 && pwm_out[0]) highs_b++;
            if (c == 10) begin
                checks++;
                if (period_tick !== 1'b1) begin failures++; $display("FAIL mid_tick: got %b want 1", period_tick); end
            end
            if (c == 4) begin cfg_wr = 1'b1; cfg_addr = 8'h00; cfg_data = 7; end
            if (c == 5) cfg_wr = 1'b0;
        end
        checks++;
        if (highs_a != 3) begin failures++; $display("FAIL mid_current_period: got %0d want 3", highs_a); end
        checks++;
        if (highs_b != 7) begin failures++; $display("FAIL mid_next_period: got %0d want 7", highs_b); end
    endtask

    task automatic test_inv();
        int bad;
        wait_tick(15, "inv_sync");
        ch_en = 3'b000; ch_inv = 3'b101;
        wait_tick(15, "inv_wrap");
        bad = 0;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) @(negedge clk_in);
            checks++;
            if ({pwm_out, period_tick, cfg_err} !== {m_pwm, m_tick, m_err}) begin
                failures++;
                $display("FAIL inv_model c=%0d: got %b/%b/%b want %b/%b/%b", c,
                         pwm_out, period_tick, cfg_err, m_pwm, m_tick, m_err);
            end
            if (c < 10 && pwm_out !== 3'b101) bad++;
            if (c == 3) ch_inv = 3'b000;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL inv_steady: got %0d bad cycles want 0", bad); end
        checks++;
        if (pwm_out !== 3'b000) begin failures++; $display("FAIL inv_after_wrap: got %b want 000", pwm_out); end
    endtask

    task automatic test_prescale_err();
        int highs, tick_at;
        cfg_write(8'hFF, 1); cfg_write(8'hFE, 4);
        cfg_write(8'h00, 2); cfg_write(8'h01, 2); cfg_write(8'h02, 2);
        ch_en = 3'b111; ch_inv = 3'b000;
        wait_tick(15, "presc_wrap");
        for (int rep = 0; rep < 2; rep++) begin
            highs = 0; tick_at = -1;
            for (int c = 0; c <= 10; c++) begin
                if (c > 0) @(negedge clk_in);
                checks++;
                if ({pwm_out, period_tick, cfg_err} !== {m_pwm, m_tick, m_err}) begin
                    failures++;
                    $display("FAIL presc_model rep=%0d c=%0d: got %b/%b/%b want %b/%b/%b", rep, c,
                             pwm_out, period_tick, cfg_err, m_pwm, m_tick, m_err);
                end
                if (c < 10 && pwm_out[0]) highs++;
                if (c > 0 && period_tick && tick_at < 0) tick_at = c;
            end
            checks++;
            if (highs != 4) begin failures++; $display("FAIL presc_high_len rep=%0d: got %0d want 4", rep, highs); end
            checks++;
            if (tick_at != 10) begin failures++; $display("FAIL presc_tick_spacing rep=%0d: got %0d want 10", rep, tick_at); end
            if (rep == 0) begin
                cfg_write(8'hFE, 0);
                checks++;
                if (cfg_err !== 1'b1) begin failures++; $display("FAIL err_period_zero: got %b want 1", cfg_err); end
                @(negedge clk_in);
                checks++;
                if (cfg_err !== 1'b0) begin failures++; $display("FAIL err_pulse_width: got %b want 0", cfg_err); end
                cfg_write(8'h05, 20'h00ABC);
                checks++;
                if (cfg_err !== 1'b1) begin failures++; $display("FAIL err_unmapped: got %b want 1", cfg_err); end
                wait_tick(15, "presc_after_err");
            end
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_in);
            checks++;
            if ({pwm_out, period_tick, cfg_err} !== {m_pwm, m_tick, m_err}) begin
                failures++;
                $display("FAIL random_model cyc=%0d: got %b/%b/%b want %b/%b/%b", cyc,
                         pwm_out, period_tick, cfg_err, m_pwm, m_tick, m_err);
            end
            cfg_wr = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                cfg_wr = 1'b1;
                case ($urandom_range(0, 5))
                    0, 1, 2: begin cfg_addr = 8'($urandom_range(0, 2)); cfg_data = CNT_W'($urandom_range(0, 15)); end
                    3: begin cfg_addr = 8'hFE; cfg_data = CNT_W'($urandom_range(0, 12)); end
                    4: begin cfg_addr = 8'hFF; cfg_data = {12'($urandom), 8'($urandom_range(0, 3))}; end
                    default: begin cfg_addr = 8'($urandom_range(3, 253)); cfg_data = CNT_W'($urandom); end
                endcase
            end
            if ($urandom_range(0, 19) == 0) begin
                ch_en  = NUM_CH'($urandom);
                ch_inv = NUM_CH'($urandom);
            end
        end
        cfg_wr = 1'b0;
    endtask

    task automatic test_reset_mid();
        int bad;
        @(posedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        checks++;
        if ({pwm_out, period_tick, cfg_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_mid_immediate: got %b want 00000", {pwm_out, period_tick, cfg_err});
        end
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1; ch_en = 3'b111; ch_inv = 3'b000; cfg_wr = 1'b0;
        bad = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk_in);
            checks++;
            if ({pwm_out, period_tick, cfg_err} !== {m_pwm, m_tick, m_err}) begin
                failures++;
                $display("FAIL reset_mid_model c=%0d: got %b/%b/%b want %b/%b/%b", c,
                         pwm_out, period_tick, cfg_err, m_pwm, m_tick, m_err);
            end
            if (pwm_out !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL reset_mid_low: got %0d bad cycles want 0", bad); end
        wait_tick(80, "reset_mid_first_wrap");
        checks++;
        if (pwm_out !== 3'b111) begin failures++; $display("FAIL reset_mid_defaults: got %b want 111", pwm_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duty_extremes();
        test_mid_period();
        test_inv();
        test_prescale_err();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
